// File: rtl/prog_delay_pkg.sv
// Shared helpers for the programmable delay line: delay-field sizing and
// clamping of requested delays to the physical depth.
package prog_delay_pkg;

    // Bits needed to encode a delay value in 0..max.
    function automatic int delay_w(input int max);
        return $clog2(max + 1);
    endfunction

    // Requested delays beyond the physical depth saturate at the deepest tap.
    function automatic int clamp_delay(input int cfg, input int max);
        return (cfg > max) ? max : cfg;
    endfunction

endpackage

// File: rtl/dly_stage.sv
// One valid-tagged pipeline register of the delay line. clr drops the valid
// bit only (payload is don't-care once invalid) and wins over en.
module dly_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             clr,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    // Stage register: clear invalidates, otherwise shift when enabled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the payload is reset too so data_out is a known 0 out of reset
            // even though it is only observed behind a valid bit.
            v <= 1'b0;
            d <= '0;
        end else if (clr) begin
            // NOTE: non-blocking assignments keep every stage sampling the
            // pre-edge value of its neighbour, which is what makes this a shift.
            v <= 1'b0;
        end else if (en) begin
            v <= v_in;
            d <= d_in;
        end
    end

endmodule

// File: rtl/prog_delay_line.sv
// Runtime-programmable, valid-tagged delay line. A chain of MAX_DELAY stages
// always shifts; the output is taken from the tap selected by active_delay,
// with tap 0 being a combinational bypass of the input.
module prog_delay_line
    import prog_delay_pkg::*;
#(
    parameter int  WIDTH       = 32,
    parameter int  MAX_DELAY   = 16,
    parameter int  RESET_DELAY = 4,
    localparam int DW          = delay_w(MAX_DELAY)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             flush,
    input  logic             cfg_load,
    input  logic [DW-1:0]    delay_cfg,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out,
    output logic [DW-1:0]    active_delay,
    output logic             primed
);

    localparam logic [DW-1:0] RST_DLY = DW'(clamp_delay(RESET_DELAY, MAX_DELAY));

    // Index 0 is the live input; index k is the output of stage k.
    logic [MAX_DELAY:0]            stg_v;
    logic [MAX_DELAY:0][WIDTH-1:0] stg_d;

    logic             clr;
    logic [DW-1:0]    cfg_clamped;
    logic [DW-1:0]    fc;
    logic             tap_v;
    logic [WIDTH-1:0] tap_d;

    // A new delay setting invalidates everything in flight, exactly like flush.
    assign clr         = flush | cfg_load;
    assign cfg_clamped = DW'(clamp_delay(int'(delay_cfg), MAX_DELAY));

    assign stg_v[0] = in_valid;
    assign stg_d[0] = data_in;

    for (genvar k = 1; k <= MAX_DELAY; k++) begin : g_stage
        dly_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk    (clk),
            .resetn (resetn),
            .en     (en),
            .clr    (clr),
            .v_in   (stg_v[k-1]),
            .d_in   (stg_d[k-1]),
            .v      (stg_v[k]),
            .d      (stg_d[k])
        );
    end

    // Active delay and fill counter; fc counts advances since the last clear,
    // saturating at the tap so primed stays high on a full line.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active_delay <= RST_DLY;
            fc           <= '0;
        end else begin
            if (cfg_load) begin
                active_delay <= cfg_clamped;
            end
            if (clr) begin
                fc <= '0;
            end else if (en && (fc != active_delay)) begin
                fc <= fc + DW'(1);
            end
        end
    end

    assign primed = (fc == active_delay);

    // Tap select: bypass for delay 0, otherwise the stage at active_delay.
    always_comb begin
        // NOTE: defaults before the loop guarantee every path assigns the tap,
        // so no latch is inferred for unmatched delay codes.
        tap_v = in_valid;
        tap_d = data_in;
        for (int k = 1; k <= MAX_DELAY; k++) begin
            if (active_delay == DW'(k)) begin
                tap_v = stg_v[k];
                tap_d = stg_d[k];
            end
        end
    end

    // Emission only happens on an advancing cycle, so a frozen sample is never
    // presented twice; data is forced to 0 when nothing is emitted.
    assign out_valid = en & tap_v;
    assign data_out  = out_valid ? tap_d : '0;

endmodule

// File: tb/tb_prog_delay_line.sv
// Scoreboard bench for prog_delay_line: the stimulus process pushes each
// sample that must emerge, with its emission cycle; a negedge monitor pops
// and compares whenever out_valid is seen.
module tb_prog_delay_line;

    localparam int WIDTH = 32;
    localparam int DW    = 5;

    logic             clk = 1'b0;
    logic             resetn;
    logic             en;
    logic             flush;
    logic             cfg_load;
    logic [DW-1:0]    delay_cfg;
    logic             in_valid;
    logic [WIDTH-1:0] data_in;
    logic             out_valid;
    logic [WIDTH-1:0] data_out;
    logic [DW-1:0]    active_delay;
    logic             primed;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    prog_delay_line #(
        .WIDTH       (WIDTH),
        .MAX_DELAY   (16),
        .RESET_DELAY (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .en           (en),
        .flush        (flush),
        .cfg_load     (cfg_load),
        .delay_cfg    (delay_cfg),
        .in_valid     (in_valid),
        .data_in      (data_in),
        .out_valid    (out_valid),
        .data_out     (data_out),
        .active_delay (active_delay),
        .primed       (primed)
    );

    always #5 clk = ~clk;

    // Free-running cycle index, advanced on every rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus; lat >= 0 means this sample must emerge lat cycles later.
    task automatic run_vec(input bit e, input bit v, input logic [WIDTH-1:0] d, input int lat);
        en       = e;
        in_valid = v;
        data_in  = d;
        if (lat >= 0) sb.push_back('{data: d, cyc: cyc + lat});
        step();
    endtask

    task automatic load_delay(input logic [DW-1:0] dly);
        cfg_load  = 1'b1;
        delay_cfg = dly;
        run_vec(1'b1, 1'b0, '0, -1);
        cfg_load  = 1'b0;
    endtask

    // Monitor: every emitted sample must be the next expected one, in its cycle.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got data %0h at cycle %0d, required no output", data_out, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("out_data", 64'(data_out), 64'(mon_e.data));
                check("out_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end else begin
            check("idle_data_zero", 64'(data_out), 64'd0);
        end
    end

    initial begin
        resetn    = 1'b0;
        en        = 1'b0;
        flush     = 1'b0;
        cfg_load  = 1'b0;
        delay_cfg = '0;
        in_valid  = 1'b0;
        data_in   = '0;

        // Reset state.
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_active_delay", 64'(active_delay), 64'd4);
        check("rst_primed", 64'(primed), 64'd0);
        resetn = 1'b1;

        // Delay 4, continuous stream 1..8; primed after the 4th advance.
        for (int i = 0; i < 8; i++) begin
            run_vec(1'b1, 1'b1, WIDTH'(i + 1), 4);
            check("fill_primed", 64'(primed), 64'((i + 1) >= 4));
        end
        repeat (4) run_vec(1'b1, 1'b0, '0, -1);

        // Delay 0: combinational bypass, primed immediately.
        load_delay(5'd0);
        check("d0_active_delay", 64'(active_delay), 64'd0);
        check("d0_primed", 64'(primed), 64'd1);
        for (int i = 0; i < 3; i++) begin
            en       = 1'b1;
            in_valid = 1'b1;
            data_in  = WIDTH'(32'hA0 + i);
            sb.push_back('{data: data_in, cyc: cyc});
            #1;
            check("d0_bypass_valid", 64'(out_valid), 64'd1);
            check("d0_bypass_data", 64'(data_out), 64'(32'hA0 + i));
            step();
        end
        en       = 1'b0;
        in_valid = 1'b1;
        data_in  = 32'hBEEF;
        #1;
        check("d0_stall_no_emit", 64'(out_valid), 64'd0);
        step();

        // Delay 3 with a two-cycle stall in the middle of the stream.
        load_delay(5'd3);
        run_vec(1'b1, 1'b1, 32'h10, 5);
        run_vec(1'b1, 1'b1, 32'h11, 5);
        for (int i = 0; i < 2; i++) begin
            en       = 1'b0;
            in_valid = 1'b1;
            data_in  = 32'hDEAD;
            #1;
            check("stall_no_emit", 64'(out_valid), 64'd0);
            check("stall_primed", 64'(primed), 64'd0);
            step();
        end
        run_vec(1'b1, 1'b1, 32'h12, 3);
        check("stall_primed_after", 64'(primed), 64'd1);
        run_vec(1'b1, 1'b1, 32'h13, 3);
        repeat (4) run_vec(1'b1, 1'b0, '0, -1);

        // Delay 5, flush mid-stream: in-flight samples dropped, 5-cycle gap.
        load_delay(5'd5);
        for (int i = 0; i < 8; i++) run_vec(1'b1, 1'b1, WIDTH'(32'h20 + i), (i < 4) ? 5 : -1);
        flush = 1'b1;
        run_vec(1'b1, 1'b1, 32'h28, -1);
        flush = 1'b0;
        check("flush_primed", 64'(primed), 64'd0);
        for (int i = 0; i < 5; i++) begin
            check("flush_gap", 64'(out_valid), 64'd0);
            if (i < 4) run_vec(1'b1, 1'b1, WIDTH'(32'h30 + i), 5);
            else       run_vec(1'b1, 1'b0, '0, -1);
        end
        repeat (5) run_vec(1'b1, 1'b0, '0, -1);

        // Oversized request clamps to 16; then cfg_load with flush together.
        load_delay(5'd31);
        check("clamp_active_delay", 64'(active_delay), 64'd16);
        check("clamp_primed", 64'(primed), 64'd0);
        run_vec(1'b1, 1'b1, 32'h40, 16);
        run_vec(1'b1, 1'b1, 32'h41, -1);
        repeat (14) run_vec(1'b1, 1'b0, '0, -1);
        cfg_load  = 1'b1;
        flush     = 1'b1;
        delay_cfg = 5'd2;
        run_vec(1'b1, 1'b0, '0, -1);
        cfg_load  = 1'b0;
        flush     = 1'b0;
        check("load_flush_active_delay", 64'(active_delay), 64'd2);
        check("load_flush_primed", 64'(primed), 64'd0);
        run_vec(1'b1, 1'b1, 32'h50, 2);
        run_vec(1'b1, 1'b1, 32'h51, 2);
        check("load_flush_primed_after", 64'(primed), 64'd1);
        repeat (3) run_vec(1'b1, 1'b0, '0, -1);

        // Delay 7, asynchronous reset mid-stream.
        load_delay(5'd7);
        for (int i = 0; i < 9; i++) run_vec(1'b1, 1'b1, WIDTH'(32'h60 + i), (i < 2) ? 7 : -1);
        en       = 1'b1;
        in_valid = 1'b0;
        #1;
        resetn = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_data_out", 64'(data_out), 64'd0);
        check("arst_active_delay", 64'(active_delay), 64'd4);
        check("arst_primed", 64'(primed), 64'd0);
        step();
        step();
        resetn = 1'b1;
        run_vec(1'b1, 1'b1, 32'h70, 4);
        repeat (5) run_vec(1'b1, 1'b0, '0, -1);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
